prog_loader: RTL and testbench

Program loader that writes the instruction memory read by the stack-machine core. It receives a framed byte stream, assembles big-endian 16-bit words, and writes them sequentially into the program memory write port. It holds the core in reset (cpu_hold) until a frame is accepted with a valid checksum. Sits between the host byte link (UART receiver) and the write port of the dual-port program ROM.

---
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream, writes big-endian 16-bit words
// into the program memory and holds the core in reset until a frame checks out.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd4096,
  parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] address_mem,
  output logic [15:0] data_mem,
  output logic        wren_mem,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  error_cause,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CNT_HI  = 3'd1;
  localparam logic [2:0] S_CNT_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  localparam logic [1:0] CAUSE_CHK     = 2'b01;
  localparam logic [1:0] CAUSE_COUNT   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  logic [2:0]  state;
  logic [7:0]  cnt_hi;
  logic [7:0]  word_hi;
  logic [7:0]  chk;
  logic [15:0] word_count;
  logic [15:0] idx;
  logic [23:0] timer;

  logic        accept;
  logic        in_frame;
  logic [15:0] count_next;
  logic [16:0] idx_inc;

  always_comb begin
    accept     = rx_valid && rx_ready;
    in_frame   = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_DATA_HI) ||
                 (state == S_DATA_LO) || (state == S_CHECK);
    count_next = {cnt_hi, rx_data};
    idx_inc    = {1'b0, idx} + 17'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      address_mem  <= '0;
      data_mem     <= '0;
      wren_mem     <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      error_cause  <= '0;
      words_loaded <= '0;
      cnt_hi       <= '0;
      word_hi      <= '0;
      chk          <= '0;
      word_count   <= '0;
      idx          <= '0;
      timer        <= '0;
    end else begin
      rx_ready <= 1'b1;
      wren_mem <= 1'b0;

      // Idle gap timer; an expiry can only happen on a cycle with no accepted byte,
      // so it never competes with the byte-handling case below.
      if (accept || !in_frame) begin
        timer <= '0;
      end else if (timer == TIMEOUT - 24'd1) begin
        timer       <= '0;
        state       <= S_ERROR;
        error       <= 1'b1;
        error_cause <= CAUSE_TIMEOUT;
      end else begin
        timer <= timer + 24'd1;
      end

      if (accept) begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (rx_data == SYNC_BYTE) begin
              state       <= S_CNT_HI;
              cpu_hold    <= 1'b1;
              done        <= 1'b0;
              error       <= 1'b0;
              error_cause <= '0;
              chk         <= '0;
            end
          end
          S_CNT_HI: begin
            cnt_hi <= rx_data;
            chk    <= chk ^ rx_data;
            state  <= S_CNT_LO;
          end
          S_CNT_LO: begin
            chk <= chk ^ rx_data;
            if (count_next > MAX_WORDS) begin
              state       <= S_ERROR;
              error       <= 1'b1;
              error_cause <= CAUSE_COUNT;
            end else begin
              word_count   <= count_next;
              idx          <= '0;
              words_loaded <= '0;
              state        <= (count_next == 16'd0) ? S_CHECK : S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            word_hi <= rx_data;
            chk     <= chk ^ rx_data;
            state   <= S_DATA_LO;
          end
          S_DATA_LO: begin
            address_mem  <= BASE_ADDR + idx;
            data_mem     <= {word_hi, rx_data};
            wren_mem     <= 1'b1;
            idx          <= idx_inc[15:0];
            words_loaded <= words_loaded + 16'd1;
            chk          <= chk ^ rx_data;
            state        <= (idx_inc < {1'b0, word_count}) ? S_DATA_HI : S_CHECK;
          end
          S_CHECK: begin
            if (rx_data == chk) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state       <= S_ERROR;
              error       <= 1'b1;
              error_cause <= CAUSE_CHK;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as frames
// are sent and matched against every wren_mem pulse.
module tb_prog_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] address_mem;
  logic [15:0] data_mem;
  logic        wren_mem;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [1:0]  error_cause;
  logic [15:0] words_loaded;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic [31:0] exp_wr_q[$];

  prog_loader #(.TIMEOUT(24'd16)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .address_mem  (address_mem),
    .data_mem     (data_mem),
    .wren_mem     (wren_mem),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .error_cause  (error_cause),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (wren_mem === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", {address_mem, data_mem}, 32'hxxxxxxxx);
      end else begin
        check("write_addr_data", {address_mem, data_mem}, exp_wr_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic end_frame();
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic send_nominal();
    logic [7:0] f [8];
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    exp_wr_q.push_back({16'h0000, 16'h1234});
    exp_wr_q.push_back({16'h0001, 16'hABCD});
    for (int unsigned i = 0; i < 8; i++) send_byte(f[i]);
    end_frame();
  endtask

  task automatic check_done(input string tag, input logic [15:0] words);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_error"}, {29'd0, error, error_cause}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, {16'd0, words});
    check({tag, "_q_empty"}, exp_wr_q.size(), 32'd0);
  endtask

  task automatic check_error(input string tag, input logic [1:0] cause);
    check({tag, "_error"}, {31'd0, error}, 32'd1);
    check({tag, "_cause"}, {30'd0, error_cause}, {30'd0, cause});
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_q_empty"}, exp_wr_q.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_addr_data"}, {address_mem, data_mem}, 32'd0);
    check({tag, "_wren"}, {31'd0, wren_mem}, 32'd0);
    check({tag, "_flags"}, {28'd0, cpu_hold, done, error, 1'b0}, 32'h8);
    check({tag, "_cause_words"}, {14'd0, error_cause, words_loaded}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b1;
    idle(2);
    check_reset_vals("reset");
    reset = 1'b0;
    idle(2);
    check("ready_after_reset", {31'd0, rx_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got_err;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;

    do_reset();

    send_nominal();
    check_done("nominal", 16'd2);

    exp_wr_q.push_back({16'h0000, 16'h1234});
    exp_wr_q.push_back({16'h0001, 16'hABCD});
    begin
      logic [7:0] f [8];
      f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
      for (int unsigned i = 0; i < 8; i++) send_byte(f[i]);
    end
    end_frame();
    check_error("badchk", 2'b01);
    check("badchk_words", {16'd0, words_loaded}, 32'd2);

    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
    end_frame();
    check_error("overflow", 2'b10);

    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end_frame();
    check_done("zero", 16'd0);

    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    end_frame();
    got_err = 1'b0;
    for (int unsigned i = 0; i < 40 && !got_err; i++) begin
      @(negedge clock);
      got_err = error;
    end
    check("timeout_seen", {31'd0, got_err}, 32'd1);
    check_error("timeout", 2'b11);

    send_nominal();
    check_done("recovery", 16'd2);

    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    end_frame();
    check("garbage_ignored", {30'd0, done, cpu_hold}, 32'h2);
    send_nominal();
    check_done("garbage_reload", 16'd2);

    exp_wr_q.push_back({16'h0000, 16'h0007});
    send_byte(8'hA5);
    send_byte(8'h00);
    check("reload_hold_on_sync", {30'd0, cpu_hold, done}, 32'h2);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h07); send_byte(8'h06);
    end_frame();
    check_done("reload", 16'd1);

    exp_wr_q.push_back({16'h0000, 16'h1234});
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
    @(negedge clock);
    rx_data = 8'hCD;
    reset   = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
    check_reset_vals("midframe_reset");
    check("midframe_q_empty", exp_wr_q.size(), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(2);
    send_nominal();
    check_done("after_reset", 16'd2);

    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
